// File: rtl/debounce_sync.sv
`default_nettype none
// ============================================================================
// Module   : debounce_sync
// Brief    : Per-bit synchroniser + stable-window debouncer with change strobe
//            and combined busy flag. Optional macro DEBOUNCE_CHANGED_EN builds
//            the registered 'changed' strobes; otherwise 'changed' is zero.
// Revision : 1.0 - initial release
// ============================================================================
module debounce_sync #(
    parameter int WIDTH         = 2,
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] raw_in,
    output logic [WIDTH-1:0] clean_out,
    output logic [WIDTH-1:0] changed,
    output logic             busy
);

    localparam int               c_CNT_W   = $clog2(STABLE_CYCLES);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(STABLE_CYCLES - 1);

    typedef enum logic [0:0] {
        ST_STABLE = 1'b0,
        ST_CHECK  = 1'b1
    } state_t;

    logic [WIDTH-1:0] w_in_check;
    logic [WIDTH-1:0] w_clean;
    logic [WIDTH-1:0] w_changed;
    logic             r_busy;

    generate
        for (genvar g = 0; g < WIDTH; g++) begin : g_ch
            logic [SYNC_STAGES-1:0] r_sync;
            logic                   w_sync_bit;
            state_t                 r_state;
            state_t                 w_state_nxt;
            logic [c_CNT_W-1:0]     r_cnt;
            logic [c_CNT_W-1:0]     w_cnt_nxt;
            logic                   w_load;
            logic                   r_clean;

            // Pure flop chain: nothing between stages.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_sync <= '0;
                end else begin
                    r_sync <= {r_sync[SYNC_STAGES-2:0], raw_in[g]};
                end
            end

            assign w_sync_bit = r_sync[SYNC_STAGES-1];

            always_comb begin
                w_state_nxt = r_state;
                w_cnt_nxt   = '0;
                w_load      = 1'b0;
                case (r_state)
                    ST_STABLE: begin
                        if (w_sync_bit != r_clean) begin
                            w_state_nxt = ST_CHECK;
                            w_cnt_nxt   = c_CNT_W'(1);
                        end
                    end
                    ST_CHECK: begin
                        if (w_sync_bit == r_clean) begin
                            w_state_nxt = ST_STABLE;
                        end else if (r_cnt == c_CNT_MAX) begin
                            w_load      = 1'b1;
                            w_state_nxt = ST_STABLE;
                        end else begin
                            w_cnt_nxt = r_cnt + c_CNT_W'(1);
                        end
                    end
                    default: begin
                        w_state_nxt = ST_STABLE;
                    end
                endcase
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_state <= ST_STABLE;
                    r_cnt   <= '0;
                    r_clean <= 1'b0;
                end else begin
                    r_state <= w_state_nxt;
                    r_cnt   <= w_cnt_nxt;
                    if (w_load) begin
                        r_clean <= w_sync_bit;
                    end
                end
            end

            assign w_clean[g]    = r_clean;
            assign w_in_check[g] = (r_state == ST_CHECK);

`ifdef DEBOUNCE_CHANGED_EN
            logic r_changed;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_changed <= 1'b0;
                end else begin
                    r_changed <= w_load;
                end
            end

            assign w_changed[g] = r_changed;
`else
            assign w_changed[g] = 1'b0;
`endif
        end
    endgenerate

    // Busy reflects the current state, so it trails CHECK entry/exit by a cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy <= 1'b0;
        end else begin
            r_busy <= |w_in_check;
        end
    end

    assign clean_out = w_clean;
    assign changed   = w_changed;
    assign busy      = r_busy;

endmodule
`default_nettype wire

// File: doc/debounce_sync.md
Name: debounce_sync

Overview:
- Per-bit input conditioner for raw switch/button lines that feed the team's combinational gate blocks (or_gate a/b inputs).
- Synchronises each raw bit into clk, rejects bounces shorter than a programmable stable window, and presents glitch-free levels downstream.
- Also provides a one-cycle change strobe per bit and a combined busy flag (OR of all channels still settling).

Parameters:
- WIDTH, 2, number of independent input channels.
- SYNC_STAGES, 2, flip-flop synchroniser depth per channel; legal values >= 2.
- STABLE_CYCLES, 8, consecutive synchronised cycles a new level must hold before acceptance; legal values >= 2. The counter width is derived internally as $clog2(STABLE_CYCLES).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- raw_in  input  WIDTH  unsynchronised raw levels.
- clean_out  output  WIDTH  debounced levels.
- changed  output  WIDTH  one-cycle pulse on each bit whose clean_out updated this cycle.
- busy  output  1  high while any channel is in CHECK.

Behaviour:
- Reset (asynchronous, effective immediately on rst=1, no clock needed):
  - all synchroniser flops = 0; clean_out = 0; changed = 0; busy = 0; all counters = 0; all channel FSMs in STABLE.
- Synchroniser: shift chain of SYNC_STAGES flops; sync_bit is the last stage. No logic is placed between stages.
- Per-channel FSM, two states:
  - STABLE: if sync_bit != clean_out bit -> CHECK, cnt = 1. Otherwise stay, cnt = 0.
  - CHECK, sync_bit == clean_out bit (bounce back): -> STABLE, cnt = 0, no output change, no pulse.
  - CHECK, mismatch, cnt < STABLE_CYCLES-1: cnt++.
  - CHECK, mismatch, cnt == STABLE_CYCLES-1: clean_out bit <= sync_bit, changed bit = 1 for exactly that cycle, -> STABLE, cnt = 0.
- Latency:
  - Count the first rising edge that samples the new raw level as edge 1.
  - clean_out updates at edge SYNC_STAGES+STABLE_CYCLES (edge 10 with defaults), provided raw_in is held.
- Glitch rule: any raw pulse that reaches sync_bit for fewer than STABLE_CYCLES consecutive cycles never changes clean_out.
- changed and clean_out are registered. changed deasserts on the edge after its pulse.
- busy = registered OR over channels of (state == CHECK). It asserts the cycle after entry to CHECK and deasserts the cycle after return to STABLE.
- Channels are fully independent. Simultaneous transitions on several bits each complete on their own schedule. Several changed bits may pulse in the same cycle.
- Reset mid-CHECK: the pending transition is discarded. After rst falls, a held level is re-qualified from scratch with the full latency.
- No wrap-around: the counter never exceeds STABLE_CYCLES-1.

Optional Feature:
- Macro: DEBOUNCE_CHANGED_EN.
- Defined: changed is generated as described above.
- Undefined: changed is tied to all-zero and its registers are not built. clean_out, busy and latency are identical in both builds.

Test Plan:
- Reset with raw_in held at 2'b11: clean_out=00, changed=00, busy=0 during reset. After rst falls, clean_out=11 at edge 10, changed=11 for one cycle at edge 10.
- Clean step, raw_in[0] 0->1 held: busy=1 from the cycle after edge 3 through edge 10. clean_out[0]=1 at edge 10. changed[0]=1 for that cycle only. clean_out[1] and changed[1] stay 0.
- Short glitch, raw_in[0] high for 5 cycles then low: clean_out stays 00 and changed never pulses. busy pulses high then returns to 0.
- Bouncy settle, raw_in[1] toggling every 3 cycles for 4 toggles then held at 1: clean_out[1] rises exactly 10 edges after the final 0->1 transition, with a single changed[1] pulse.
- Independent channels, raw_in[0] rises at edge 1 and raw_in[1] rises at edge 4, both held: clean_out[0] rises at edge 10, clean_out[1] rises at edge 13, giving two separate changed pulses.
- Reset mid-qualification: raw_in[0] rises, rst pulses at edge 6. Outputs go to 0 asynchronously. After release with raw held at 1, clean_out[0] rises 10 edges after release. Build without DEBOUNCE_CHANGED_EN: changed=00 throughout.
